rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single asynchronous-read program ROM between two requesters: port 0 (instruction fetch) and port 1 (data/constant load).
- Arbitrates per cycle with round-robin priority and drives the ROM address from the granted port.
- Captures the ROM read data into a per-port response register and returns it over a valid/ready handshake.
- Sits between the fetch/load units and the ROM instance; it is the only driver of the ROM address.

Parameters:
- ADDRESS_WIDTH, 8, ROM address width; also the width of both request address ports.
- DATA_WIDTH, 8, ROM word width; also the width of both response data ports.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  port 0 request present.
- req0_addr  input  ADDRESS_WIDTH  port 0 read address.
- req0_ready  output  1  port 0 request accepted this cycle.
- rsp0_valid  output  1  port 0 response data valid.
- rsp0_data  output  DATA_WIDTH  port 0 response word.
- rsp0_ready  input  1  port 0 consumer takes response.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_ready: same as port 0, for port 1.
- rom_a  output  ADDRESS_WIDTH  ROM address, combinational.
- rom_rd  input  DATA_WIDTH  ROM read data, combinational from rom_a.

Behaviour:
- Reset (async assert, sync release):
  - rsp0_valid=0, rsp1_valid=0; rsp0_data=0, rsp1_data=0.
  - Priority pointer prio=0, so port 0 wins the first conflict.
  - req0_ready and req1_ready are 0 while rst_n is low.
- Slot free condition: port i is eligible when rsp_i_valid=0, or when rsp_i_valid=1 and rsp_i_ready=1 in the same cycle (drain and refill back-to-back).
- Grant (combinational):
  - Among ports with req_i_valid=1 and an eligible slot, grant the single port prio points to if it qualifies, otherwise the other port.
  - At most one grant per cycle.
- Grant outputs:
  - req_i_ready=1 only for the granted port.
  - rom_a = granted port's address.
  - With no grant, rom_a = req0_addr (a don't-care, but defined for deterministic sims).
  - req_i_ready never depends on rom_rd.
- Acceptance:
  - A transfer occurs when req_i_valid and req_i_ready are both high.
  - On that edge, rsp_i_data <= rom_rd and rsp_i_valid <= 1.
  - Latency is exactly 1 cycle: accept in cycle N, rsp_i_valid high in N+1.
- Response hold:
  - While rsp_i_valid=1 and rsp_i_ready=0, rsp_i_data is stable and the port is not granted.
  - When rsp_i_ready=1 with no new accept, rsp_i_valid <= 0. rsp_i_data holds its last value.
- Round-robin update:
  - After any grant to port i, prio <= ~i.
  - No grant leaves prio unchanged.
  - With both ports requesting continuously and both drained every cycle, grants alternate 0,1,0,1.
- Throughput: one accept per cycle aggregate; a single port alone can accept every cycle if its response is drained every cycle.
- Input stability: the arbiter does not buffer requests. A requester must hold req_addr stable while req_valid=1 and not yet accepted. The arbiter does not check this.
- Responses are returned strictly in request order per port; ports are independent.
- Reset mid-operation: pending responses are discarded (valid cleared) and prio returns to 0. No response is emitted for a request accepted in the cycle reset asserts.
- Responses never cross ports: port 0 data is never presented on rsp1 and vice versa.

Test Plan:
- Reset, then single request: ROM word at 0x10 = 0xA5; req0 valid at addr 0x10 in cycle 1 -> req0_ready=1 and rom_a=0x10 in cycle 1; rsp0_valid=1, rsp0_data=0xA5 in cycle 2; rsp1_valid stays 0.
- Conflict with round-robin: both ports request every cycle, req0_addr=0x01 (word 0x11), req1_addr=0x02 (word 0x22), both rsp_ready=1 -> grants in order port0, port1, port0, port1; rsp0_data=0x11 and rsp1_data=0x22 each one cycle after their grant.
- Backpressure: rsp0_ready=0 after one accept -> rsp0_data held stable for 5 cycles; req0_ready=0 throughout; port 1 granted every cycle meanwhile; raising rsp0_ready with req0 still valid -> port 0 re-accepted in that same cycle.
- Back-to-back single port: req0 streams addresses 0x00 to 0x07 with rsp0_ready=1 -> 8 accepts in 8 consecutive cycles; rsp0_data matches ROM[0..7] in order, each one cycle after its accept.
- Reset mid-flight: assert rst_n=0 while rsp1_valid=1 -> rsp1_valid drops immediately (asynchronously); after release, a simultaneous req0/req1 conflict is granted to port 0 first.
- Address wrap: with ADDRESS_WIDTH=8, read 0xFF then 0x00 on port 1 -> correct words returned in order; no bleed of port 1 data onto rsp0.

Source files
------------

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a single asynchronous-read ROM.
// Each port gets a one-deep response register returned over valid/ready.
module rom_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  output logic                     req0_ready,
  output logic                     rsp0_valid,
  output logic [DATA_WIDTH-1:0]    rsp0_data,
  input  logic                     rsp0_ready,
  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  output logic                     req1_ready,
  output logic                     rsp1_valid,
  output logic [DATA_WIDTH-1:0]    rsp1_data,
  input  logic                     rsp1_ready,
  output logic [ADDRESS_WIDTH-1:0] rom_a,
  input  logic [DATA_WIDTH-1:0]    rom_rd
);

  logic                  prio_q, prio_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;

  logic slot0_free, slot1_free;
  logic cand0, cand1;
  logic gnt0, gnt1;

  // A slot that is draining this cycle can be refilled on the same edge.
  always_comb begin
    slot0_free = !rsp0_valid_q || rsp0_ready;
    slot1_free = !rsp1_valid_q || rsp1_ready;
    cand0      = rst_n && req0_valid && slot0_free;
    cand1      = rst_n && req1_valid && slot1_free;
    gnt0       = cand0 && (!prio_q || !cand1);
    gnt1       = cand1 && !gnt0;
  end

  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    rom_a      = gnt1 ? req1_addr : req0_addr;
  end

  always_comb begin
    prio_d       = prio_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;

    if (gnt0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = rom_rd;
      prio_d       = 1'b1;
    end else if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (gnt1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = rom_rd;
      prio_d       = 1'b0;
    end else if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      prio_q       <= prio_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: ROM model is ~addr except a few
// overridden words (0x01=0x11, 0x02=0x22, 0x10=0xA5).
module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_addr, req1_addr;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic       rsp0_ready, rsp1_ready;
  logic [7:0] rom_a, rom_rd;
  logic [7:0] rom_mem [256];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign rom_rd = rom_mem[rom_a];

  rom_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .rom_a(rom_a), .rom_rd(rom_rd)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v0, input logic [7:0] a0, input logic r0,
                                input logic v1, input logic [7:0] a1, input logic r1);
    req0_valid = v0; req0_addr = a0; rsp0_ready = r0;
    req1_valid = v1; req1_addr = a1; rsp1_ready = r1;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] stream_exp [8];

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = ~i[7:0];
    rom_mem[8'h01] = 8'h11;
    rom_mem[8'h02] = 8'h22;
    rom_mem[8'h10] = 8'hA5;
    stream_exp = '{8'hFF, 8'h11, 8'h22, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8};

    // Reset: requests present but nothing granted
    rst_n = 1'b0;
    apply_stimulus(1'b1, 8'h10, 1'b0, 1'b1, 8'h02, 1'b0);
    tick();
    check_output("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check_output("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check_output("rst_rsp0_data", 32'(rsp0_data), 32'h00);
    check_output("rst_rsp1_data", 32'(rsp1_data), 32'h00);
    check_output("rst_req0_ready", 32'(req0_ready), 32'd0);
    check_output("rst_req1_ready", 32'(req1_ready), 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single request on port 0
    apply_stimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
    check_output("single_req0_ready", 32'(req0_ready), 32'd1);
    check_output("single_req1_ready", 32'(req1_ready), 32'd0);
    check_output("single_rom_a", 32'(rom_a), 32'h10);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    check_output("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check_output("single_rsp0_data", 32'(rsp0_data), 32'hA5);
    check_output("single_rsp1_valid", 32'(rsp1_valid), 32'd0);
    tick();
    check_output("single_drain_valid", 32'(rsp0_valid), 32'd0);
    check_output("single_drain_hold", 32'(rsp0_data), 32'hA5);

    // Re-reset so the conflict starts from prio=0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Round-robin conflict: grants 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 8'h01, 1'b1, 1'b1, 8'h02, 1'b1);
      check_output($sformatf("rr%0d_req0_ready", k), 32'(req0_ready), 32'((k % 2) == 0));
      check_output($sformatf("rr%0d_req1_ready", k), 32'(req1_ready), 32'((k % 2) == 1));
      check_output($sformatf("rr%0d_rom_a", k), 32'(rom_a), ((k % 2) == 0) ? 32'h01 : 32'h02);
      tick();
      if ((k % 2) == 0) begin
        check_output($sformatf("rr%0d_rsp0_valid", k), 32'(rsp0_valid), 32'd1);
        check_output($sformatf("rr%0d_rsp0_data", k), 32'(rsp0_data), 32'h11);
        check_output($sformatf("rr%0d_rsp1_valid", k), 32'(rsp1_valid), 32'd0);
      end else begin
        check_output($sformatf("rr%0d_rsp1_valid", k), 32'(rsp1_valid), 32'd1);
        check_output($sformatf("rr%0d_rsp1_data", k), 32'(rsp1_data), 32'h22);
        check_output($sformatf("rr%0d_rsp0_valid", k), 32'(rsp0_valid), 32'd0);
      end
    end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    check_output("rr_idle_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check_output("rr_idle_rsp1_valid", 32'(rsp1_valid), 32'd0);

    // Backpressure on port 0 while port 1 streams
    apply_stimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1);
    check_output("bp_first_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 8'h01, 1'b0, 1'b1, 8'h02, 1'b1);
      check_output($sformatf("bp%0d_req0_ready", k), 32'(req0_ready), 32'd0);
      check_output($sformatf("bp%0d_req1_ready", k), 32'(req1_ready), 32'd1);
      check_output($sformatf("bp%0d_rom_a", k), 32'(rom_a), 32'h02);
      tick();
      check_output($sformatf("bp%0d_rsp0_valid", k), 32'(rsp0_valid), 32'd1);
      check_output($sformatf("bp%0d_rsp0_data", k), 32'(rsp0_data), 32'hA5);
      check_output($sformatf("bp%0d_rsp1_data", k), 32'(rsp1_data), 32'h22);
    end
    apply_stimulus(1'b1, 8'h01, 1'b1, 1'b1, 8'h02, 1'b1);
    check_output("bp_release_req0_ready", 32'(req0_ready), 32'd1);
    check_output("bp_release_req1_ready", 32'(req1_ready), 32'd0);
    check_output("bp_release_rom_a", 32'(rom_a), 32'h01);
    tick();
    check_output("bp_release_rsp0_data", 32'(rsp0_data), 32'h11);
    check_output("bp_release_rsp0_valid", 32'(rsp0_valid), 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    tick();

    // Back-to-back stream on port 0
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 8'(i), 1'b1, 1'b0, 8'h00, 1'b1);
      check_output($sformatf("stream%0d_req0_ready", i), 32'(req0_ready), 32'd1);
      check_output($sformatf("stream%0d_rom_a", i), 32'(rom_a), 32'(i));
      tick();
      check_output($sformatf("stream%0d_rsp0_valid", i), 32'(rsp0_valid), 32'd1);
      check_output($sformatf("stream%0d_rsp0_data", i), 32'(rsp0_data), 32'(stream_exp[i]));
    end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    tick();

    // Reset while port 1 holds a response
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0);
    check_output("midrst_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    check_output("midrst_pre_rsp1_valid", 32'(rsp1_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_output("midrst_async_rsp1_valid", 32'(rsp1_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    apply_stimulus(1'b1, 8'h01, 1'b1, 1'b1, 8'h02, 1'b1);
    check_output("midrst_conf_req0_ready", 32'(req0_ready), 32'd1);
    check_output("midrst_conf_req1_ready", 32'(req1_ready), 32'd0);
    check_output("midrst_conf_rom_a", 32'(rom_a), 32'h01);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    check_output("midrst_conf_rsp0_data", 32'(rsp0_data), 32'h11);
    check_output("midrst_conf_rsp1_valid", 32'(rsp1_valid), 32'd0);
    tick();

    // Address wrap on port 1: 0xFF then 0x00
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1);
    check_output("wrap_ff_req1_ready", 32'(req1_ready), 32'd1);
    check_output("wrap_ff_rom_a", 32'(rom_a), 32'hFF);
    tick();
    check_output("wrap_ff_rsp1_data", 32'(rsp1_data), 32'h00);
    check_output("wrap_ff_rsp0_valid", 32'(rsp0_valid), 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
    check_output("wrap_00_rom_a", 32'(rom_a), 32'h00);
    tick();
    check_output("wrap_00_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check_output("wrap_00_rsp1_data", 32'(rsp1_data), 32'hFF);
    check_output("wrap_rsp0_data_kept", 32'(rsp0_data), 32'h11);
    check_output("wrap_rsp0_valid", 32'(rsp0_valid), 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
